note_tone_gen: RTL and testbench
================================

Name: note_tone_gen

Overview:
- Consumes the 27-bit note word produced by the song memory reader.
- Converts it into a 1-bit square-wave audio output for the speaker pin.
- The note word is a half-period in clk cycles; 0 means rest.
- Frequency changes only at half-period boundaries, so there are no glitches. An optional retrigger inserts a short silent gap so repeated identical notes are heard separately.

Parameters:
NOTE_W, 27, width of note word and of the half-period counter.
GAP_CYCLES, 50000, length of the silent articulation gap in clk cycles (must be >= 1).
GAP_W, 16, width of the gap counter (must hold GAP_CYCLES-1).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
note  input  NOTE_W  requested half-period in clk cycles; 0 = rest; sampled every cycle.
enable  input  1  1 = playback allowed; 0 = go silent at next boundary.
retrig  input  1  single-cycle pulse: re-articulate the current note (new note event).
audio  output  1  square-wave speaker drive.
playing  output  1  1 while state is TONE.
note_ack  output  1  one-cycle pulse when a new half-period value is latched into cur.

Behaviour:
- Reset (async, active-high):
  - state=SILENT; cur=0; cnt=0; gcnt=0; pend=0.
  - audio=0; playing=0; note_ack=0.
- All outputs are registered; note_ack defaults to 0 every cycle unless set below.
- SILENT:
  - audio held 0, cnt=0.
  - If enable && note!=0: cur<=note, cnt<=0, state<=TONE, note_ack<=1.
  - retrig is ignored in SILENT.
- TONE:
  - cnt increments each cycle.
  - Boundary is cnt==cur-1. At the boundary cnt<=0, then the first matching rule applies:
    1. pend || retrig this cycle -> state<=GAP, audio<=0, gcnt<=0, pend<=0.
    2. !enable || note==0 -> state<=SILENT, audio<=0.
    3. note!=cur -> cur<=note, note_ack<=1, audio toggles.
    4. Otherwise audio toggles.
  - A retrig pulse on a non-boundary cycle sets pend<=1 and is held until the boundary.
  - enable and note changes on non-boundary cycles have no effect until the boundary.
- GAP:
  - audio=0; gcnt increments.
  - At gcnt==GAP_CYCLES-1:
    - if enable && note!=0: cur<=note, cnt<=0, note_ack<=1, state<=TONE;
    - else state<=SILENT.
  - retrig in GAP is ignored; no pend set.
- Timing and width rules:
  - Latency from SILENT: note valid at edge N gives TONE and note_ack high after edge N. The first audio rise is at edge N+cur, so the full period is 2*cur cycles.
  - cur==1: audio toggles every cycle (period 2).
  - No overflow is possible: cnt < cur <= 2^NOTE_W-1.
  - Sub-boundary note changes never shorten or lengthen the half-period in progress.
- Simultaneous events:
  - retrig plus a note change at the same boundary: GAP wins; the new note is latched at gap end.
  - Reset asserted mid-TONE or mid-GAP: immediately return to reset values, with no trailing pulse.

Test Plan:
- Reset, then enable=1, note=4 -> note_ack pulses 1 cycle. audio 0 for 4 cycles, then 1 for 4 cycles, then 0 for 4 cycles; playing=1 throughout.
- Tone at note=4, change note to 6 two cycles after a rising edge -> the current high half lasts exactly 4 cycles. note_ack pulses at that boundary; subsequent halves are 6 cycles.
- Tone at note=4, retrig pulse mid-half, GAP_CYCLES=10 -> at the next boundary audio=0 and playing=0 for 10 cycles. Then note_ack and TONE resume; first rise 4 cycles later.
- Tone at note=3, drop enable (or set note=0) -> audio finishes the current half, then stays 0, state SILENT. Re-enable -> restart with note_ack.
- note=1 -> audio toggles every cycle. Assert reset mid-high -> audio=0 and playing=0 immediately, with no clock edge required.
- Retrig and note change 4->5 on the same boundary cycle -> gap first; after the gap note_ack fires with cur=5, giving 5-cycle halves.

Source files
------------

// File: rtl/note_tone_gen.sv
// note_tone_gen: turns a half-period note word into a glitch-free square wave.
// A new frequency only takes effect at a half-period boundary, and a retrigger
// inserts a silent gap so repeated identical notes are articulated separately.
//
// state  | meaning
// SILENT | no tone; waiting for enable with a non-zero note
// TONE   | square wave running; cnt counts cycles within the current half
// GAP    | silent articulation gap after a retrigger; gcnt counts gap cycles
module note_tone_gen #(
  parameter int NOTE_W     = 27,
  parameter int GAP_CYCLES = 50000,
  parameter int GAP_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note,
  input  logic              enable,
  input  logic              retrig,
  output logic              audio,
  output logic              playing,
  output logic              note_ack
);

  typedef enum logic [1:0] {SILENT, TONE, GAP} state_t;

  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [NOTE_W-1:0] NOTE_ONE = NOTE_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

  state_t            state;
  logic [NOTE_W-1:0] cur;
  logic [NOTE_W-1:0] cnt;
  logic [GAP_W-1:0]  gcnt;
  logic              pend;
  logic              note_live;

  // A note is playable only when enabled and not a rest.
  assign note_live = enable && (note != '0);

  // Single sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SILENT;
      cur      <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      pend     <= 1'b0;
      audio    <= 1'b0;
      playing  <= 1'b0;
      note_ack <= 1'b0;
    end else begin
      note_ack <= 1'b0;
      case (state)
        SILENT: begin
          audio <= 1'b0;
          cnt   <= '0;
          if (note_live) begin
            cur      <= note;
            state    <= TONE;
            playing  <= 1'b1;
            note_ack <= 1'b1;
          end
        end
        TONE: begin
          if (cnt == cur - NOTE_ONE) begin
            cnt <= '0;
            // Retrigger (held or arriving now) beats every note/enable change.
            if (pend || retrig) begin
              state   <= GAP;
              playing <= 1'b0;
              audio   <= 1'b0;
              gcnt    <= '0;
              pend    <= 1'b0;
            end else if (!note_live) begin
              state   <= SILENT;
              playing <= 1'b0;
              audio   <= 1'b0;
            end else begin
              if (note != cur) begin
                cur      <= note;
                note_ack <= 1'b1;
              end
              audio <= ~audio;
            end
          end else begin
            cnt <= cnt + NOTE_ONE;
            if (retrig) pend <= 1'b1;
          end
        end
        GAP: begin
          audio <= 1'b0;
          if (gcnt == GAP_LAST) begin
            gcnt <= '0;
            if (note_live) begin
              cur      <= note;
              cnt      <= '0;
              note_ack <= 1'b1;
              state    <= TONE;
              playing  <= 1'b1;
            end else begin
              state <= SILENT;
            end
          end else begin
            gcnt <= gcnt + GAP_ONE;
          end
        end
        default: begin
          state   <= SILENT;
          playing <= 1'b0;
          audio   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed literal checks plus randomized stimulus
// compared every cycle against a half-period countdown model.
module tb_note_tone_gen;

  localparam int NOTE_W = 27;
  localparam int GAP    = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [NOTE_W-1:0] note;
  logic              enable;
  logic              retrig;
  logic              audio;
  logic              playing;
  logic              note_ack;

  int checks   = 0;
  int failures = 0;

  note_tone_gen #(.NOTE_W(NOTE_W), .GAP_CYCLES(GAP), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .note(note), .enable(enable), .retrig(retrig),
    .audio(audio), .playing(playing), .note_ack(note_ack)
  );

  always #5 clk = ~clk;

  // Model: mode 0=silent 1=tone 2=gap; m_left counts down cycles left in the half.
  int      m_mode  = 0;
  longint  m_cur   = 0;
  longint  m_left  = 0;
  int      m_gleft = 0;
  bit      m_pend  = 0;
  bit      m_audio = 0;
  bit      m_ack   = 0;

  always @(posedge clk or posedge reset) begin
    bit live;
    if (reset) begin
      m_mode = 0; m_cur = 0; m_left = 0; m_gleft = 0;
      m_pend = 0; m_audio = 0; m_ack = 0;
    end else begin
      live  = enable && (note != 0);
      m_ack = 0;
      case (m_mode)
        0: if (live) begin
          m_cur = note; m_left = note; m_mode = 1; m_ack = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            if (m_pend || retrig) begin
              m_mode = 2; m_gleft = GAP; m_pend = 0; m_audio = 0;
            end else if (!live) begin
              m_mode = 0; m_audio = 0;
            end else begin
              if (longint'(note) != m_cur) begin
                m_cur = note; m_ack = 1;
              end
              m_left  = m_cur;
              m_audio = !m_audio;
            end
          end else if (retrig) begin
            m_pend = 1;
          end
        end
        default: begin
          m_gleft--;
          if (m_gleft == 0) begin
            if (live) begin
              m_mode = 1; m_cur = note; m_left = note; m_ack = 1;
            end else begin
              m_mode = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("model_audio", audio, m_audio);
    chk("model_playing", playing, (m_mode == 1));
    chk("model_note_ack", note_ack, m_ack);
  end

  initial begin
    logic [11:0] seq12;
    logic [15:0] seq16;
    logic [15:0] ack16;
    bit          found;

    reset = 1'b1; note = '0; enable = 1'b0; retrig = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_audio", audio, 0);
    chk("reset_playing", playing, 0);
    chk("reset_ack", note_ack, 0);
    reset = 1'b0;

    // Start tone with half-period 4.
    @(negedge clk);
    enable = 1'b1; note = NOTE_W'(4);
    @(negedge clk);
    chk("start_ack", note_ack, 1);
    chk("start_playing", playing, 1);
    seq12 = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      seq12 = {seq12[10:0], audio};
    end
    chk("first_periods", seq12, 12'b0000_1111_0000);

    // Two cycles into the next high half, change to 6: high half stays 4 long.
    @(negedge clk);
    @(negedge clk);
    note = NOTE_W'(6);
    seq16 = '0; ack16 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seq16 = {seq16[14:0], audio};
      ack16 = {ack16[14:0], note_ack};
    end
    chk("note_change_audio", seq16, 16'b1100_0000_1111_1100);
    chk("note_change_ack", ack16, 16'b0010_0000_0000_0000);

    // Half-period 1, then async reset while audio is high.
    note = NOTE_W'(1);
    repeat (20) @(negedge clk);
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (audio) found = 1;
      else @(negedge clk);
    end
    chk("fast_tone_high_seen", found, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_audio", audio, 0);
    chk("async_reset_playing", playing, 0);
    chk("async_reset_ack", note_ack, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized phase.
    note = NOTE_W'(4); enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      retrig = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) note = NOTE_W'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) enable = !enable;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
